// File: rtl/frog_game_pkg.sv
// Shared types and widths for the frog game-rule blocks: box geometry,
// game state encoding and HUD counter widths.
package frog_game_pkg;

    localparam int COORD_W = 12;
    localparam int LIVES_W = 3;
    localparam int SCORE_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        DYING     = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frog_collision_box_overlap.sv
// Combinational box-vs-box overlap test; edges that merely touch do not count.
module box_overlap
    import frog_game_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);

    assign hit = (a.x1 < b.x2) && (a.x2 > b.x1) &&
                 (a.y1 < b.y2) && (a.y2 > b.y1);

endmodule

// File: rtl/frog_collision.sv
// Frog game rules: per-frame collision, goal detection, lives/score/game-over.
// Optional per-life timeout is built when FROG_COLL_TIMEOUT_EN is defined.
module frog_collision
    import frog_game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 30,
    parameter int GOAL_Y       = 20,
    parameter int TIME_FRAMES  = 1800
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ani_stb,
    input  logic               i_animate,
    input  logic               i_restart,
    input  logic [COORD_W-1:0] i_frog_x1,
    input  logic [COORD_W-1:0] i_frog_x2,
    input  logic [COORD_W-1:0] i_frog_y1,
    input  logic [COORD_W-1:0] i_frog_y2,
    input  logic               i_obs_valid,
    input  logic               i_obs_last,
    input  logic [COORD_W-1:0] i_obs_x1,
    input  logic [COORD_W-1:0] i_obs_x2,
    input  logic [COORD_W-1:0] i_obs_y1,
    input  logic [COORD_W-1:0] i_obs_y2,
    output logic               o_dead,
    output logic               o_goal,
    output logic [LIVES_W-1:0] o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_game_over
);

    localparam int DCNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [DCNT_W-1:0]  DEATH_LAST = DCNT_W'(DEATH_FRAMES - 1);
    localparam logic [COORD_W-1:0] GOAL_Y_C   = COORD_W'(GOAL_Y);
    localparam logic [LIVES_W-1:0] LIVES_C    = LIVES_W'(LIVES);

    box_t   frog_box;
    box_t   obs_box;
    logic   obs_hit;
    logic   frame_tick;
    logic   in_play;
    logic   frame_hit;
    logic   timeout;

    state_t             state_reg;
    logic               hit_reg;
    logic               last_reg;
    logic               hit_acc_reg;
    logic [DCNT_W-1:0]  death_cnt_reg;
    logic               dead_reg;
    logic               goal_reg;
    logic               game_over_reg;
    logic [LIVES_W-1:0] lives_reg;
    logic [SCORE_W-1:0] score_reg;

    assign frog_box   = {i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2};
    assign obs_box    = {i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2};
    assign frame_tick = i_ani_stb && i_animate;
    assign in_play    = (state_reg == PLAY);

    box_overlap u_overlap (
        .a   (frog_box),
        .b   (obs_box),
        .hit (obs_hit)
    );

    // The frame verdict includes the result arriving alongside the last flag.
    assign frame_hit = last_reg && (hit_acc_reg || hit_reg);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_reg     <= 1'b0;
            last_reg    <= 1'b0;
            hit_acc_reg <= 1'b0;
        end else begin
            hit_reg  <= in_play && i_obs_valid && obs_hit;
            last_reg <= in_play && i_obs_valid && i_obs_last;
            if (!in_play || last_reg) begin
                hit_acc_reg <= 1'b0;
            end else if (hit_reg) begin
                hit_acc_reg <= 1'b1;
            end
        end
    end

`ifdef FROG_COLL_TIMEOUT_EN
    localparam logic [COORD_W-1:0] TIME_LAST = COORD_W'(TIME_FRAMES - 1);
    logic [COORD_W-1:0] time_cnt_reg;

    // Held at zero outside PLAY so every life starts with a full budget.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            time_cnt_reg <= '0;
        end else if (!in_play) begin
            time_cnt_reg <= '0;
        end else if (frame_tick) begin
            time_cnt_reg <= time_cnt_reg + 1'b1;
        end
    end

    assign timeout = in_play && frame_tick && (time_cnt_reg == TIME_LAST);
`else
    localparam int time_frames_unused = TIME_FRAMES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= PLAY;
            death_cnt_reg <= '0;
            dead_reg      <= 1'b0;
            goal_reg      <= 1'b0;
            game_over_reg <= 1'b0;
            lives_reg     <= LIVES_C;
            score_reg     <= '0;
        end else begin
            goal_reg <= 1'b0;
            case (state_reg)
                PLAY: begin
                    // Collision and timeout both outrank a goal on the same edge.
                    if (frame_hit || timeout) begin
                        state_reg     <= DYING;
                        dead_reg      <= 1'b1;
                        lives_reg     <= lives_reg - 1'b1;
                        death_cnt_reg <= '0;
                    end else if (frame_tick && (i_frog_y1 <= GOAL_Y_C)) begin
                        state_reg <= RESPAWN;
                        dead_reg  <= 1'b1;
                        goal_reg  <= 1'b1;
                        score_reg <= score_inc(score_reg);
                    end
                end
                DYING: begin
                    if (frame_tick) begin
                        if (death_cnt_reg == DEATH_LAST) begin
                            death_cnt_reg <= '0;
                            if (lives_reg == '0) begin
                                state_reg     <= GAME_OVER;
                                game_over_reg <= 1'b1;
                            end else begin
                                state_reg <= PLAY;
                                dead_reg  <= 1'b0;
                            end
                        end else begin
                            death_cnt_reg <= death_cnt_reg + 1'b1;
                        end
                    end
                end
                RESPAWN: begin
                    if (frame_tick) begin
                        state_reg <= PLAY;
                        dead_reg  <= 1'b0;
                    end
                end
                GAME_OVER: begin
                    if (i_restart) begin
                        state_reg     <= PLAY;
                        dead_reg      <= 1'b0;
                        game_over_reg <= 1'b0;
                        lives_reg     <= LIVES_C;
                        score_reg     <= '0;
                    end
                end
                default: state_reg <= PLAY;
            endcase
        end
    end

    assign o_dead      = dead_reg;
    assign o_goal      = goal_reg;
    assign o_lives     = lives_reg;
    assign o_score     = score_reg;
    assign o_game_over = game_over_reg;

endmodule

// File: tb/tb_frog_collision.sv
// Scoreboard bench for frog_collision: expected output changes (value and
// cycle) are queued by the stimulus; a negedge monitor checks each change.
module tb_frog_collision;
    import frog_game_pkg::*;

    localparam int DEATH = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ani_stb, animate, restart;
    logic [11:0] frog_x1, frog_x2, frog_y1, frog_y2;
    logic        obs_valid, obs_last;
    logic [11:0] obs_x1, obs_x2, obs_y1, obs_y2;
    logic        dead, goal, game_over;
    logic [2:0]  lives;
    logic [7:0]  score;

    always #5 clk = ~clk;

    frog_collision #(
        .LIVES(3), .DEATH_FRAMES(DEATH), .GOAL_Y(20), .TIME_FRAMES(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_restart(restart),
        .i_frog_x1(frog_x1), .i_frog_x2(frog_x2), .i_frog_y1(frog_y1), .i_frog_y2(frog_y2),
        .i_obs_valid(obs_valid), .i_obs_last(obs_last),
        .i_obs_x1(obs_x1), .i_obs_x2(obs_x2), .i_obs_y1(obs_y1), .i_obs_y2(obs_y2),
        .o_dead(dead), .o_goal(goal), .o_lives(lives), .o_score(score),
        .o_game_over(game_over)
    );

    typedef struct packed {
        logic       dead;
        logic       goal;
        logic [2:0] lives;
        logic [7:0] score;
        logic       go;
    } out_t;

    out_t  exp_v[$];
    int    exp_c[$];
    string exp_n[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output tuple is one transaction.
    out_t cur, prev, ev;
    bit   have_prev = 1'b0;
    int   ec;
    string en;
    always @(negedge clk) begin
        cur = {dead, goal, lives, score, game_over};
        if (!have_prev || cur != prev) begin
            vectors++;
            if (exp_v.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got %h at cyc %0d, required no change", cur, cyc);
            end else begin
                ev = exp_v.pop_front();
                ec = exp_c.pop_front();
                en = exp_n.pop_front();
                if (cur !== ev || cyc != ec) begin
                    miscompares++;
                    $display("FAIL %s: got %h at cyc %0d, required %h at cyc %0d", en, cur, cyc, ev, ec);
                end else begin
                    $display("ok   %s: %h at cyc %0d", en, cur, cyc);
                end
            end
        end
        prev = cur;
        have_prev = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input string n, input logic d, input logic g,
                             input logic [2:0] l, input logic [7:0] s,
                             input logic go, input int c);
        exp_v.push_back({d, g, l, s, go});
        exp_c.push_back(c);
        exp_n.push_back(n);
    endtask

    task automatic set_frog_y(input logic [11:0] y1);
        frog_y1 = y1;
        frog_y2 = y1 + 12'd22;
    endtask

    task automatic send_obs(input logic [11:0] x1, input logic [11:0] x2,
                            input logic [11:0] y1, input logic [11:0] y2,
                            input logic last);
        obs_x1 = x1; obs_x2 = x2; obs_y1 = y1; obs_y2 = y2;
        obs_valid = 1'b1;
        obs_last  = last;
        step();
        obs_valid = 1'b0;
        obs_last  = 1'b0;
    endtask

    task automatic tick();
        ani_stb = 1'b1;
        step();
        ani_stb = 1'b0;
        step();
    endtask

    // One hit frame, then the full death sequence. with_goal places the frog
    // in the goal zone and lands a frame tick on the evaluation edge.
    task automatic collide(input string nm, input logic [2:0] lv, input logic [7:0] sc,
                           input bit over, input bit with_goal);
        int n;
        obs_x1 = 12'd300; obs_x2 = 12'd340;
        if (with_goal) begin
            set_frog_y(12'd20);
            obs_y1 = 12'd10; obs_y2 = 12'd40;
        end else begin
            obs_y1 = 12'd440; obs_y2 = 12'd480;
        end
        n = cyc;
        expect_ev({nm, "_dead"}, 1'b1, 1'b0, lv, sc, 1'b0, n + 2);
        obs_valid = 1'b1;
        obs_last  = 1'b1;
        step();
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        if (with_goal) ani_stb = 1'b1;
        step();
        ani_stb = 1'b0;
        set_frog_y(12'd449);
        step();
        animate = 1'b0;
        tick();
        tick();
        animate = 1'b1;
        send_obs(12'd300, 12'd340, 12'd440, 12'd480, 1'b1);
        step();
        step();
        for (int k = 0; k < DEATH - 1; k++) tick();
        n = cyc;
        if (over) expect_ev({nm, "_over"}, 1'b1, 1'b0, 3'd0, sc, 1'b1, n + 1);
        else      expect_ev({nm, "_play"}, 1'b0, 1'b0, lv, sc, 1'b0, n + 1);
        tick();
    endtask

    task automatic do_goal(input string nm, input logic [2:0] lv, input logic [7:0] sc);
        int n;
        set_frog_y(12'd20);
        n = cyc;
        expect_ev({nm, "_pulse"}, 1'b1, 1'b1, lv, sc, 1'b0, n + 1);
        expect_ev({nm, "_end"},   1'b1, 1'b0, lv, sc, 1'b0, n + 2);
        tick();
        set_frog_y(12'd449);
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        n = cyc;
        expect_ev({nm, "_play"}, 1'b0, 1'b0, lv, sc, 1'b0, n + 1);
        tick();
    endtask

    task automatic do_restart(input string nm);
        int n;
        n = cyc;
        expect_ev(nm, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0, n + 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b1; restart = 1'b0;
        frog_x1 = 12'd309; frog_x2 = 12'd331;
        frog_y1 = 12'd449; frog_y2 = 12'd471;
        obs_valid = 1'b0; obs_last = 1'b0;
        obs_x1 = '0; obs_x2 = '0; obs_y1 = '0; obs_y2 = '0;
        expect_ev("reset", 1'b0, 1'b0, 3'd3, 8'd0, 1'b0, 1);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        step();

        collide("col1", 3'd2, 8'd0, 1'b0, 1'b0);

        // Abutting right edge and abutting top edge: no hit.
        send_obs(12'd331, 12'd350, 12'd449, 12'd471, 1'b0);
        send_obs(12'd300, 12'd340, 12'd400, 12'd449, 1'b1);
        repeat (4) step();

        // Just outside goal zone: no goal.
        set_frog_y(12'd21);
        tick();
        set_frog_y(12'd449);
        do_goal("goal1", 3'd2, 8'd1);

        // Restart outside GAME_OVER is ignored.
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();

        collide("col_goal", 3'd1, 8'd1, 1'b0, 1'b1);
        collide("col2", 3'd0, 8'd1, 1'b1, 1'b0);
        do_restart("restart1");

        collide("run_a", 3'd2, 8'd0, 1'b0, 1'b0);
        collide("run_b", 3'd1, 8'd0, 1'b0, 1'b0);
        collide("run_c", 3'd0, 8'd0, 1'b1, 1'b0);
        do_restart("restart2");

        // Reset in the middle of a frame that already holds a hit.
        do_goal("goal2", 3'd3, 8'd1);
        send_obs(12'd0, 12'd100, 12'd0, 12'd100, 1'b0);
        send_obs(12'd300, 12'd340, 12'd440, 12'd480, 1'b0);
        send_obs(12'd500, 12'd600, 12'd0, 12'd100, 1'b0);
        n = cyc;
        expect_ev("midframe_reset", 1'b0, 1'b0, 3'd3, 8'd0, 1'b0, n);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        send_obs(12'd0, 12'd100, 12'd0, 12'd100, 1'b0);
        send_obs(12'd500, 12'd600, 12'd0, 12'd100, 1'b1);
        repeat (4) step();

        // Five ticks in PLAY: a timeout death only when the feature is built.
        for (int k = 0; k < 6; k++) begin
`ifdef FROG_COLL_TIMEOUT_EN
            if (k == 4) expect_ev("timeout", 1'b1, 1'b0, 3'd2, 8'd0, 1'b0, cyc + 1);
`endif
            tick();
        end
        repeat (4) step();

        vectors++;
        if (exp_v.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events: got %0d pending, required 0 (next %s)",
                     exp_v.size(), exp_n[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frog_collision.md
Name: frog_collision

Overview:
- Game-rule block that consumes the frog's bounding box (12-bit edges) and a per-frame stream of obstacle boxes.
- Decides collision, goal-reached and per-life timeout.
- Drives o_dead, which wires straight to the frog position block's dead input. That input forces the frog back to its start position on animation strobes.
- Also owns lives, score and game-over state for the HUD.

Parameters:
- LIVES, 3, lives at start/restart (1..7)
- DEATH_FRAMES, 30, animation strobes o_dead is held after a collision (>=1)
- GOAL_Y, 20, frog top edge <= GOAL_Y counts as goal reached
- TIME_FRAMES, 1800, per-life frame budget (optional feature only)

Ports:
- i_clk  in  1  base clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ani_stb  in  1  animation strobe
- i_animate  in  1  animation enable; a "frame tick" is i_ani_stb && i_animate
- i_restart  in  1  single-cycle request to leave GAME_OVER
- i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2  in  12 each  frog box edges
- i_obs_valid  in  1  obstacle box valid this cycle
- i_obs_last  in  1  last obstacle of current frame (qualified by valid)
- i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2  in  12 each  obstacle box edges
- o_dead  out  1  respawn request to frog block
- o_goal  out  1  one-cycle pulse on goal reached
- o_lives  out  3  remaining lives
- o_score  out  8  goals scored, saturating
- o_game_over  out  1  high in GAME_OVER

Behaviour:
- Async reset values: state=PLAY, o_dead=0, o_goal=0, o_lives=LIVES, o_score=0, o_game_over=0. Hit accumulator, pipeline registers and counters are all 0.
- Overlap test is unsigned with strict inequalities: fx1<ox2 && fx2>ox1 && fy1<oy2 && fy2>oy1. Abutting edges do not hit.
- Pipeline: a compare result is registered the cycle after i_obs_valid. It ORs into a sticky hit flag. The last flag travels with the result.
- Frame evaluation happens the cycle the registered last result is present. If hit is set, go to DYING on the next edge. o_dead is therefore high 2 cycles after the valid&&last cycle. The hit flag clears at evaluation.
- Obstacle stream is ignored (no compare, no accumulate) outside PLAY. The hit flag is cleared on every entry to PLAY.
- States:
  - PLAY: o_dead=0.
    - Collision evaluation -> DYING, decrement o_lives.
    - Frame tick with i_frog_y1<=GOAL_Y -> RESPAWN: o_goal pulses 1 cycle, o_score+1 saturating at 255.
    - Collision and goal in the same cycle: collision wins, no score.
  - DYING: o_dead=1; count DEATH_FRAMES frame ticks. After the last tick -> GAME_OVER if o_lives==0, else PLAY.
  - RESPAWN: o_dead=1 until and including the next frame tick, then PLAY. This guarantees the frog block samples dead once.
  - GAME_OVER: o_dead=1, o_game_over=1.
    - i_restart -> PLAY with o_lives=LIVES, o_score=0.
    - i_restart in any other state is ignored.
- o_lives never underflows; a decrement from 0 cannot occur because GAME_OVER is entered first.
- Frame ticks during i_animate=0 do not count.
- Reset asserted mid-DYING or mid-stream aborts immediately to reset values. A partially accumulated frame is discarded.

Optional Feature:
- Macro FROG_COLL_TIMEOUT_EN.
- Defined:
  - A 12-bit frame-tick counter runs in PLAY only. It clears on every entry to PLAY.
  - Reaching TIME_FRAMES is treated exactly as a collision evaluation (-> DYING, lives-1).
  - Priority: collision > timeout > goal.
- Undefined: no counter, no timeout; TIME_FRAMES is unused.

Decomposition:
- Package frog_game_pkg:
  - COORD_W=12
  - box type (x1, x2, y1, y2)
  - state enum {PLAY, DYING, RESPAWN, GAME_OVER}
  - LIVES_W=3, SCORE_W=8
- Sub-module box_overlap: purely combinational strict-inequality compare of two boxes, output hit. Instantiated once in front of the pipeline register.

Test Plan:
- Frog box 309..331 x 449..471; one obstacle 300..340 x 440..480 with last -> o_dead rises 2 cycles later, o_lives 3->2. Exactly DEATH_FRAMES=30 frame ticks later o_dead=0, state PLAY.
- Obstacle 331..350 x 449..471 (abuts frog right edge) with last -> no hit, o_dead stays 0, o_lives=3.
- Frog y1=20 at a frame tick -> o_goal single-cycle pulse, o_score 0->1. o_dead=1 through the next tick, then 0. Also: collision and goal in the same cycle -> DYING, o_score unchanged.
- Three successive collisions from LIVES=3 -> o_lives=0, GAME_OVER after the third DYING, o_game_over=1, o_dead=1. i_restart pulse -> o_lives=3, o_score=0, o_dead=0.
- Hit on obstacle 2 of 4, then i_rst_n low before last -> all outputs at reset values. The next frame with no overlapping obstacle produces no death.
- FROG_COLL_TIMEOUT_EN with TIME_FRAMES=5: 5 frame ticks in PLAY with no hits -> DYING, o_lives 3->2. With the macro undefined, same stimulus -> no death.
